stack_flow_sequencer: RTL and testbench
=======================================

Name: stack_flow_sequencer

Overview:
- Parametrised sequential successor to the control unit's fixed CALL/RET decode.
- Executes CALL, RET, RETI, RST and interrupt dispatch as a handshaked multi-cycle sequence.
- Owns the stack pointer and pushes/pops a return address of configurable width over a byte-wide memory port.
- Sits between the control unit, which issues one op per i_Start, and the bus arbiter.

Parameters:
- ADDR_WIDTH, 16, PC/SP width. Multiple of 8, range 8..32. NB = ADDR_WIDTH/8 bytes per push/pop.
- COND_COUNT, 4, number of condition flags selectable.
- INTERNAL_WAIT, 1, idle cycles inserted: before the first push byte (CALL/RST/INT) or after the last pop byte (RET/RETI). Range 0..3.
- SP_RESET, 16'hFFFE, SP value after reset. Width is ADDR_WIDTH.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Reset  in  1  asynchronous active-high reset.
- i_Start  in  1  op request; accepted only in IDLE.
- i_Op  in  3  0=CALL 1=RET 2=RETI 3=RST 4=INT; 5..7 treated as a not-taken no-op.
- i_Cond_En  in  1  1 = conditional op (CALL/RET only).
- i_Cond_Sel  in  clog2(COND_COUNT)  flag index.
- i_Conditions  in  COND_COUNT  flag vector.
- i_PC  in  ADDR_WIDTH  return address to push.
- i_Target  in  ADDR_WIDTH  CALL target.
- i_RST_Index  in  3  RST vector = index*8.
- i_Int_Vector  in  ADDR_WIDTH  INT target.
- i_SP_Load  in  1  load SP from i_SP_Value; honoured only in IDLE.
- i_SP_Value  in  ADDR_WIDTH  SP load value.
- o_Busy  out  1  high whenever state != IDLE.
- o_Taken  out  1  registered; valid from the cycle after accept until o_Done.
- o_Done  out  1  one-cycle completion pulse.
- o_PC_Load  out  1  one-cycle pulse coincident with o_Done when taken.
- o_PC_Value  out  ADDR_WIDTH  new PC, valid with o_PC_Load.
- o_SP  out  ADDR_WIDTH  current SP.
- o_Mem_Req  out  1  byte access request.
- o_Mem_Write  out  1  1 = write (push), 0 = read (pop).
- o_Mem_Addr  out  ADDR_WIDTH  access address.
- o_Mem_WData  out  8  push data.
- i_Mem_Ack  in  1  access completes in the cycle Req&Ack.
- i_Mem_RData  in  8  pop data, valid with Ack.
- o_EI  out  1  pulse with o_Done on RETI.
- o_DI  out  1  pulse with o_Done on INT.

Behaviour:
- Reset:
  - State IDLE; SP=SP_RESET; all pulses/Req/Busy/Taken=0; o_PC_Value=0.
  - Reset mid-op aborts with no o_Done and no SP change beyond bytes already acked.
- States: IDLE, WAIT, PUSH, POP, FINISH.
- Accept (IDLE & i_Start):
  - Capture op, target, PC.
  - taken = !i_Cond_En | i_Conditions[i_Cond_Sel], for CALL/RET only. RETI/RST/INT are always taken.
  - Not taken -> FINISH.
  - CALL/RST/INT -> WAIT, or PUSH if INTERNAL_WAIT=0.
  - RET/RETI -> POP.
- WAIT: counts INTERNAL_WAIT cycles, then -> PUSH (push ops) or FINISH (pop ops).
- PUSH:
  - Req=1, Write=1, Addr=SP-1, bytes MSB first.
  - On Ack: SP<=SP-1, next byte. After byte NB -> FINISH.
  - Req and Addr/WData are held stable until Ack.
- POP:
  - Req=1, Write=0, Addr=SP, bytes LSB first, assembled little-endian.
  - On Ack: SP<=SP+1. After NB bytes -> WAIT, or FINISH if INTERNAL_WAIT=0.
- FINISH:
  - o_Done=1.
  - If taken, o_PC_Load=1 and o_PC_Value is one of: target (CALL), popped value (RET/RETI), {index,3'b000} zero-extended (RST), i_Int_Vector captured at accept (INT).
  - o_EI / o_DI as listed. Next state IDLE.
- Latency with zero-stall Ack: taken op -> o_Done at accept+1+INTERNAL_WAIT+NB; not taken -> accept+1.
- SP arithmetic is modulo 2^ADDR_WIDTH (wraps 0->max on push, max->0 on pop).
- i_Start while busy is ignored (not queued). Start and SP_Load in the same IDLE cycle: SP_Load applied first, op uses the new SP.
- Ack while Req=0 is ignored.

Test Plan:
- Conditional CALL, flag set, SP=FFFE, PC=1234, target=4000, Ack tied 1 -> writes 12@FFFD then 34@FFFC; SP=FFFC; o_PC_Load with 4000 and o_Done at accept+4.
- RET from SP=FFFC holding 34,12 -> reads FFFC, FFFD; SP=FFFE; PC_Value=1234 at accept+4. Repeat with RETI -> additionally o_EI=1 with o_Done.
- Conditional CALL, flag clear -> no Req, o_Taken=0, o_Done at accept+1, SP unchanged.
- Ack withheld 3 cycles on first push byte -> Req/Addr/WData stable during the stall; o_Done delayed by 3 cycles.
- SP=0001, RST index 7, PC=ABCD -> writes AB@0000, CD@FFFF; SP=FFFF; PC_Value=0038.
- Reset asserted during PUSH -> immediate IDLE, SP=FFFE, no o_Done. Also run with ADDR_WIDTH=24, INT, vector 000040 -> 3 byte writes, o_DI pulse, o_Done at accept+5.

Source files
------------

// File: rtl/stack_flow_sequencer.sv
// Stack flow sequencer: runs CALL/RET/RETI/RST/INT as handshaked multi-cycle
// sequences, owns the stack pointer and moves return addresses over a byte port.
module stack_flow_sequencer #(
  parameter int unsigned            ADDR_WIDTH    = 16,
  parameter int unsigned            COND_COUNT    = 4,
  parameter int unsigned            INTERNAL_WAIT = 1,
  parameter logic [ADDR_WIDTH-1:0]  SP_RESET      = ADDR_WIDTH'(16'hFFFE)
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Start,
  input  logic [2:0]                  i_Op,
  input  logic                        i_Cond_En,
  input  logic [((COND_COUNT > 1) ? $clog2(COND_COUNT) : 1)-1:0] i_Cond_Sel,
  input  logic [COND_COUNT-1:0]       i_Conditions,
  input  logic [ADDR_WIDTH-1:0]       i_PC,
  input  logic [ADDR_WIDTH-1:0]       i_Target,
  input  logic [2:0]                  i_RST_Index,
  input  logic [ADDR_WIDTH-1:0]       i_Int_Vector,
  input  logic                        i_SP_Load,
  input  logic [ADDR_WIDTH-1:0]       i_SP_Value,
  output logic                        o_Busy,
  output logic                        o_Taken,
  output logic                        o_Done,
  output logic                        o_PC_Load,
  output logic [ADDR_WIDTH-1:0]       o_PC_Value,
  output logic [ADDR_WIDTH-1:0]       o_SP,
  output logic                        o_Mem_Req,
  output logic                        o_Mem_Write,
  output logic [ADDR_WIDTH-1:0]       o_Mem_Addr,
  output logic [7:0]                  o_Mem_WData,
  input  logic                        i_Mem_Ack,
  input  logic [7:0]                  i_Mem_RData,
  output logic                        o_EI,
  output logic                        o_DI
);

  localparam int unsigned NB        = ADDR_WIDTH / 8;
  localparam logic [2:0]  LAST_BYTE = 3'(NB - 1);
  localparam logic [1:0]  WAIT_LAST = 2'((INTERNAL_WAIT == 0) ? 0 : INTERNAL_WAIT - 1);

  localparam logic [2:0] OP_CALL = 3'd0;
  localparam logic [2:0] OP_RET  = 3'd1;
  localparam logic [2:0] OP_RETI = 3'd2;
  localparam logic [2:0] OP_RST  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_PUSH   = 3'd2,
    S_POP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sp_q, sp_d;
  logic [2:0]              op_q, op_d;
  logic                    taken_q, taken_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]   ret_q, ret_d;
  logic [2:0]              byte_idx_q, byte_idx_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pc_load_q, pc_load_d;
  logic [ADDR_WIDTH-1:0]   pc_value_q, pc_value_d;
  logic                    req_q, req_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    ei_q, ei_d;
  logic                    di_q, di_d;

  logic                    cond_ok;
  logic                    take;
  logic                    push_op;
  logic                    pop_op;
  logic [2:0]              push_shift;

  assign cond_ok = !i_Cond_En || i_Conditions[i_Cond_Sel];

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      sp_q       <= SP_RESET;
      op_q       <= '0;
      taken_q    <= 1'b0;
      pc_q       <= '0;
      tgt_q      <= '0;
      ret_q      <= '0;
      byte_idx_q <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
      req_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ei_q       <= 1'b0;
      di_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      op_q       <= op_d;
      taken_q    <= taken_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      ret_q      <= ret_d;
      byte_idx_q <= byte_idx_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
      req_q      <= req_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ei_q       <= ei_d;
      di_q       <= di_d;
    end
  end

  // Next-state sequencing, then registered outputs derived from next-state values.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    op_d       = op_q;
    taken_d    = taken_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    ret_d      = ret_q;
    byte_idx_d = byte_idx_q;
    wait_cnt_d = wait_cnt_q;
    pc_value_d = pc_value_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    pc_load_d  = 1'b0;
    ei_d       = 1'b0;
    di_d       = 1'b0;
    take       = 1'b0;
    push_shift = '0;

    unique case (state_q)
      S_IDLE: begin
        // SP load lands first so an op accepted in the same cycle uses it.
        if (i_SP_Load) sp_d = i_SP_Value;
        if (i_Start) begin
          op_d       = i_Op;
          pc_d       = i_PC;
          ret_d      = '0;
          byte_idx_d = '0;
          wait_cnt_d = '0;
          case (i_Op)
            OP_CALL: begin tgt_d = i_Target; take = cond_ok; end
            OP_RET:  take = cond_ok;
            OP_RETI: take = 1'b1;
            OP_RST:  begin tgt_d = ADDR_WIDTH'({i_RST_Index, 3'b000}); take = 1'b1; end
            OP_INT:  begin tgt_d = i_Int_Vector; take = 1'b1; end
            default: take = 1'b0;
          endcase
          taken_d = take;
          if (!take)                               state_d = S_FINISH;
          else if (i_Op == OP_RET || i_Op == OP_RETI) state_d = S_POP;
          else if (INTERNAL_WAIT == 0)             state_d = S_PUSH;
          else                                     state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = (op_q == OP_RET || op_q == OP_RETI) ? S_FINISH : S_PUSH;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_PUSH: begin
        if (i_Mem_Ack) begin
          sp_d = sp_q - ADDR_WIDTH'(1);
          if (byte_idx_q == LAST_BYTE) state_d = S_FINISH;
          else                         byte_idx_d = byte_idx_q + 3'd1;
        end
      end
      S_POP: begin
        if (i_Mem_Ack) begin
          sp_d  = sp_q + ADDR_WIDTH'(1);
          ret_d = ret_q | (ADDR_WIDTH'(i_Mem_RData) << {byte_idx_q, 3'b000});
          if (byte_idx_q == LAST_BYTE) state_d = (INTERNAL_WAIT == 0) ? S_FINISH : S_WAIT;
          else                         byte_idx_d = byte_idx_q + 3'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    push_op = (op_d == OP_CALL) || (op_d == OP_RST) || (op_d == OP_INT);
    pop_op  = (op_d == OP_RET) || (op_d == OP_RETI);

    if (state_d == S_IDLE) taken_d = 1'b0;

    busy_d  = (state_d != S_IDLE);
    req_d   = (state_d == S_PUSH) || (state_d == S_POP);
    write_d = (state_d == S_PUSH);

    // Push addresses SP-1 MSB first; pop addresses SP.
    if (state_d == S_PUSH) begin
      push_shift = LAST_BYTE - byte_idx_d;
      addr_d     = sp_d - ADDR_WIDTH'(1);
      wdata_d    = 8'(pc_d >> {push_shift, 3'b000});
    end else if (state_d == S_POP) begin
      addr_d     = sp_d;
    end

    if (state_d == S_FINISH) begin
      done_d = 1'b1;
      if (taken_d) begin
        pc_load_d  = 1'b1;
        pc_value_d = pop_op ? ret_d : tgt_d;
        ei_d       = (op_d == OP_RETI);
        di_d       = (op_d == OP_INT);
      end
    end
    if (!push_op && !pop_op) pc_load_d = 1'b0;
  end

  assign o_Busy      = busy_q;
  assign o_Taken     = taken_q;
  assign o_Done      = done_q;
  assign o_PC_Load   = pc_load_q;
  assign o_PC_Value  = pc_value_q;
  assign o_SP        = sp_q;
  assign o_Mem_Req   = req_q;
  assign o_Mem_Write = write_q;
  assign o_Mem_Addr  = addr_q;
  assign o_Mem_WData = wdata_q;
  assign o_EI        = ei_q;
  assign o_DI        = di_q;

endmodule

// File: tb/tb_stack_flow_sequencer.sv
// Directed bench for stack_flow_sequencer: 16-bit instance plus a 24-bit instance for INT.
module tb_stack_flow_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 16-bit instance signals
  logic        rst;
  logic        start, cond_en, sp_load, ack;
  logic [2:0]  op, rst_idx;
  logic [1:0]  cond_sel;
  logic [3:0]  conds;
  logic [15:0] pc, target, int_vec, sp_value;
  logic        busy, taken, done, pc_load, req, wr, ei, di;
  logic [15:0] pc_value, sp, addr;
  logic [7:0]  wdata, rdata;
  logic [7:0]  mem [16];

  // 24-bit instance signals
  logic        b_start;
  logic [23:0] b_pc, b_vec;
  logic        b_busy, b_taken, b_done, b_pc_load, b_req, b_wr, b_ei, b_di;
  logic [23:0] b_pc_value, b_sp, b_addr;
  logic [7:0]  b_wdata;

  stack_flow_sequencer #(.ADDR_WIDTH(16), .COND_COUNT(4), .INTERNAL_WAIT(1),
                         .SP_RESET(16'hFFFE)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Op(op),
    .i_Cond_En(cond_en), .i_Cond_Sel(cond_sel), .i_Conditions(conds),
    .i_PC(pc), .i_Target(target), .i_RST_Index(rst_idx), .i_Int_Vector(int_vec),
    .i_SP_Load(sp_load), .i_SP_Value(sp_value),
    .o_Busy(busy), .o_Taken(taken), .o_Done(done), .o_PC_Load(pc_load),
    .o_PC_Value(pc_value), .o_SP(sp), .o_Mem_Req(req), .o_Mem_Write(wr),
    .o_Mem_Addr(addr), .o_Mem_WData(wdata), .i_Mem_Ack(ack), .i_Mem_RData(rdata),
    .o_EI(ei), .o_DI(di));

  stack_flow_sequencer #(.ADDR_WIDTH(24), .COND_COUNT(4), .INTERNAL_WAIT(1),
                         .SP_RESET(24'h00FFFE)) dut24 (
    .i_Clk(clk), .i_Reset(rst), .i_Start(b_start), .i_Op(3'd4),
    .i_Cond_En(1'b0), .i_Cond_Sel(2'd0), .i_Conditions(4'd0),
    .i_PC(b_pc), .i_Target(24'd0), .i_RST_Index(3'd0), .i_Int_Vector(b_vec),
    .i_SP_Load(1'b0), .i_SP_Value(24'd0),
    .o_Busy(b_busy), .o_Taken(b_taken), .o_Done(b_done), .o_PC_Load(b_pc_load),
    .o_PC_Value(b_pc_value), .o_SP(b_sp), .o_Mem_Req(b_req), .o_Mem_Write(b_wr),
    .o_Mem_Addr(b_addr), .o_Mem_WData(b_wdata), .i_Mem_Ack(1'b1), .i_Mem_RData(8'h00),
    .o_EI(b_ei), .o_DI(b_di));

  // Byte memory model indexed by the low address nibble
  always @(posedge clk) if (req && ack && wr) mem[addr[3:0]] <= wdata;
  always_comb rdata = mem[addr[3:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; op = 3'd0; cond_en = 1'b0; cond_sel = 2'd0; conds = 4'd0;
    pc = 16'h0; target = 16'h0; rst_idx = 3'd0; int_vec = 16'h0; sp_load = 1'b0;
    sp_value = 16'h0; ack = 1'b1; b_start = 1'b0; b_pc = 24'h0; b_vec = 24'h0;
    #3;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sp", 32'(sp), 32'hFFFE);
    check("rst_pcval", 32'(pc_value), 32'h0);
    check("rst_req", 32'(req), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_taken", 32'(taken), 32'h0);
    tick();
    rst = 1'b0;

    // Conditional CALL, flag set; start held one extra cycle while busy
    op = 3'd0; cond_en = 1'b1; cond_sel = 2'd2; conds = 4'b0100;
    pc = 16'h1234; target = 16'h4000; start = 1'b1;
    tick();
    check("call_busy", 32'(busy), 32'h1);
    check("call_taken", 32'(taken), 32'h1);
    check("call_wait_req", 32'(req), 32'h0);
    tick(); start = 1'b0;
    check("call_b0_req", 32'({req, wr}), 32'h3);
    check("call_b0_addr", 32'(addr), 32'hFFFD);
    check("call_b0_data", 32'(wdata), 32'h12);
    tick();
    check("call_b1_addr", 32'(addr), 32'hFFFC);
    check("call_b1_data", 32'(wdata), 32'h34);
    check("call_b1_sp", 32'(sp), 32'hFFFD);
    tick();
    check("call_done", 32'({done, pc_load, ei, di}), 32'hC);
    check("call_pcval", 32'(pc_value), 32'h4000);
    check("call_sp", 32'(sp), 32'hFFFC);
    check("call_req_off", 32'(req), 32'h0);
    tick();
    check("call_idle", 32'({busy, done}), 32'h0);

    // RET unconditional from SP=FFFC
    op = 3'd1; cond_en = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    check("ret_b0", 32'({req, wr}), 32'h2);
    check("ret_b0_addr", 32'(addr), 32'hFFFC);
    tick();
    check("ret_b1_addr", 32'(addr), 32'hFFFD);
    check("ret_b1_sp", 32'(sp), 32'hFFFD);
    tick();
    check("ret_wait", 32'({req, done}), 32'h0);
    check("ret_wait_sp", 32'(sp), 32'hFFFE);
    tick();
    check("ret_done", 32'({done, pc_load, ei, di}), 32'hC);
    check("ret_pcval", 32'(pc_value), 32'h1234);
    tick();

    // RETI with SP_Load in the same cycle; condition clear must not matter
    op = 3'd2; cond_en = 1'b1; conds = 4'b0000; sp_load = 1'b1; sp_value = 16'hFFFC; start = 1'b1;
    tick(); start = 1'b0; sp_load = 1'b0;
    check("reti_addr", 32'(addr), 32'hFFFC);
    check("reti_taken", 32'(taken), 32'h1);
    tick(); tick(); tick();
    check("reti_done", 32'({done, pc_load, ei, di}), 32'hE);
    check("reti_pcval", 32'(pc_value), 32'h1234);
    check("reti_sp", 32'(sp), 32'hFFFE);
    tick();
    check("reti_ei_pulse", 32'(ei), 32'h0);

    // Conditional CALL, flag clear
    op = 3'd0; cond_en = 1'b1; cond_sel = 2'd1; conds = 4'b1101; start = 1'b1;
    tick(); start = 1'b0;
    check("nt_done", 32'({done, pc_load, taken, req}), 32'h8);
    check("nt_sp", 32'(sp), 32'hFFFE);
    tick();
    check("nt_idle", 32'(busy), 32'h0);

    // Op 5 is a no-op, not taken
    op = 3'd5; start = 1'b1;
    tick(); start = 1'b0;
    check("nop_done", 32'({done, pc_load, taken, req}), 32'h8);
    tick();

    // Ack withheld 3 cycles on first push byte
    op = 3'd0; cond_en = 1'b0; pc = 16'h5678; target = 16'h2222; start = 1'b1;
    tick(); start = 1'b0; ack = 1'b0;
    tick();
    check("stall_c2", 32'({req, wr, addr, wdata}), 32'h03FFFD56);
    tick();
    check("stall_c3", 32'({req, wr, addr, wdata}), 32'h03FFFD56);
    tick();
    check("stall_c4", 32'({req, wr, addr, wdata}), 32'h03FFFD56);
    check("stall_nodone", 32'(done), 32'h0);
    tick();
    check("stall_c5", 32'({req, wr, addr, wdata}), 32'h03FFFD56);
    ack = 1'b1;
    tick();
    check("stall_b1", 32'({addr, wdata}), 32'hFFFC78);
    tick();
    check("stall_done", 32'({done, pc_load}), 32'h3);
    check("stall_pcval", 32'(pc_value), 32'h2222);
    check("stall_sp", 32'(sp), 32'hFFFC);
    tick();

    // RST 7 from SP=0001 wraps through 0000
    op = 3'd3; rst_idx = 3'd7; pc = 16'hABCD; sp_load = 1'b1; sp_value = 16'h0001; start = 1'b1;
    tick(); start = 1'b0; sp_load = 1'b0;
    tick();
    check("rst7_b0", 32'({addr, wdata}), 32'h0000AB);
    tick();
    check("rst7_b1", 32'({addr, wdata}), 32'hFFFFCD);
    check("rst7_b1_sp", 32'(sp), 32'h0000);
    tick();
    check("rst7_done", 32'({done, pc_load}), 32'h3);
    check("rst7_pcval", 32'(pc_value), 32'h0038);
    check("rst7_sp", 32'(sp), 32'hFFFF);
    tick();

    // Reset in the middle of a push
    op = 3'd0; pc = 16'h1111; target = 16'h3333; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("abort_pre_sp", 32'(sp), 32'hFFFE);
    rst = 1'b1;
    #1;
    check("abort_state", 32'({busy, req, done, taken}), 32'h0);
    check("abort_sp", 32'(sp), 32'hFFFE);
    tick();
    check("abort_nodone", 32'({done, pc_load}), 32'h0);
    rst = 1'b0;
    tick();
    check("abort_idle", 32'(busy), 32'h0);

    // 24-bit INT dispatch
    b_pc = 24'h123456; b_vec = 24'h000040; b_start = 1'b1;
    tick(); b_start = 1'b0;
    check("int_wait", 32'({b_busy, b_req}), 32'h2);
    tick();
    check("int_b0", 32'({b_addr, b_wdata}), 32'hFFFD12);
    tick();
    check("int_b1", 32'({b_addr, b_wdata}), 32'hFFFC34);
    tick();
    check("int_b2", 32'({b_addr, b_wdata}), 32'hFFFB56);
    check("int_nodone", 32'(b_done), 32'h0);
    tick();
    check("int_done", 32'({b_done, b_pc_load, b_ei, b_di}), 32'hD);
    check("int_pcval", 32'(b_pc_value), 32'h000040);
    check("int_sp", 32'(b_sp), 32'h00FFFB);
    tick();
    check("int_idle", 32'({b_busy, b_done, b_di}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
